// File: rtl/vehicle_pin_driver.sv
// Vehicle/terminal model feeding controlador: raises arrival sensor A, shifts a PIN out on C/D,
// waits for the gate (Aguja), then walks the vehicle past sensor B. Retries on timeout, aborts on alarm/lock.
module vehicle_pin_driver #(
  parameter int PIN_BITS    = 16,
  parameter int TIMEOUT     = 32,
  parameter int PASS_CYCLES = 4,
  parameter int MAX_TRIES   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PIN_BITS-1:0] pin,
  input  logic                Aguja,
  input  logic                Bloqueo,
  input  logic                Alarma,
  output logic                A,
  output logic                B,
  output logic                C,
  output logic                D,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [1:0]          tries
);

  localparam int IW = (PIN_BITS > 1) ? $clog2(PIN_BITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ARRIVE, SEND, WAIT_GATE, PASS, FINISH} state_t;

  state_t              state;
  logic [PIN_BITS-1:0] pin_q;
  logic [PIN_BITS-1:0] shift_q;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       timer;
  logic [PW-1:0]       pcnt;
  logic                abort;

  always_comb begin
    abort = Alarma | Bloqueo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pin_q   <= '0;
      shift_q <= '0;
      idx     <= '0;
      timer   <= '0;
      pcnt    <= '0;
      A       <= 1'b0;
      B       <= 1'b0;
      C       <= 1'b0;
      D       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      tries   <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pin_q <= pin;
            tries <= '0;
            A     <= 1'b1;
            busy  <= 1'b1;
            state <= ARRIVE;
          end
        end
        ARRIVE: begin
          // Outputs are registered, so the first bit is loaded one state ahead.
          D       <= 1'b1;
          C       <= pin_q[PIN_BITS-1];
          shift_q <= pin_q << 1;
          idx     <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (abort) begin
            A     <= 1'b0;
            C     <= 1'b0;
            D     <= 1'b0;
            fail  <= 1'b1;
            state <= FINISH;
          end else if (idx == IW'(PIN_BITS - 1)) begin
            C     <= 1'b0;
            D     <= 1'b0;
            timer <= '0;
            if (tries != 2'd3) tries <= tries + 2'd1;
            state <= WAIT_GATE;
          end else begin
            C       <= shift_q[PIN_BITS-1];
            shift_q <= shift_q << 1;
            idx     <= idx + 1'b1;
          end
        end
        WAIT_GATE: begin
          if (abort) begin
            A     <= 1'b0;
            fail  <= 1'b1;
            state <= FINISH;
          end else if (Aguja) begin
            A     <= 1'b0;
            B     <= 1'b1;
            pcnt  <= '0;
            state <= PASS;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            if (int'(tries) < MAX_TRIES) begin
              D       <= 1'b1;
              C       <= pin_q[PIN_BITS-1];
              shift_q <= pin_q << 1;
              idx     <= '0;
              state   <= SEND;
            end else begin
              A     <= 1'b0;
              fail  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PASS: begin
          if (pcnt == PW'(PASS_CYCLES - 1)) begin
            B     <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vehicle_pin_driver.sv
// Scoreboard bench for vehicle_pin_driver: directed transactions push expected PIN bits and
// done/fail records; a negedge monitor pops and compares whenever D, done or fail appear.
module tb_vehicle_pin_driver;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pin;
  logic        Aguja;
  logic        Bloqueo;
  logic        Alarma;
  logic        A, B, C, D, busy, done, fail;
  logic [1:0]  tries;

  typedef struct {
    int kind;  // 0 = PIN bit, 1 = done, 2 = fail
    int val;   // bit value, or tries at done/fail
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  vehicle_pin_driver #(
    .PIN_BITS(16),
    .TIMEOUT(32),
    .PASS_CYCLES(4),
    .MAX_TRIES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .pin(pin),
    .Aguja(Aguja),
    .Bloqueo(Bloqueo),
    .Alarma(Alarma),
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .busy(busy),
    .done(done),
    .fail(fail),
    .tries(tries)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [15:0] p, input int n);
    for (int k = 0; k < n; k++) q.push_back('{0, int'(p[15-k])});
  endtask

  task automatic sb_pop(input int kind, input int val, input string name);
    exp_t e;
    if (q.size() == 0) begin
      check({name, "_unexpected"}, kind, -1);
      return;
    end
    e = q.pop_front();
    check({name, "_kind"}, kind, e.kind);
    check({name, "_val"}, val, e.val);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (D) begin
        sb_pop(0, int'(C), "pin_bit");
        check("a_during_d", int'(A), 1);
      end
      if (done) sb_pop(1, int'(tries), "done_tries");
      if (fail) sb_pop(2, int'(tries), "fail_tries");
    end
  end

  // which: 0=D, 1=B, 2=busy, 3=done
  task automatic wait_sig(input int which, input logic val, input string name);
    logic s;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      case (which)
        0:       s = D;
        1:       s = B;
        2:       s = busy;
        default: s = done;
      endcase
      if (s == val) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  // Raise Aguja on the (n+1)-th WAIT_GATE cycle and hold it until B appears.
  task automatic gate(input int n);
    wait_sig(0, 1'b1, "d_rise");
    wait_sig(0, 1'b0, "d_fall");
    repeat (n) @(negedge clock);
    Aguja = 1'b1;
    wait_sig(1, 1'b1, "b_rise");
    Aguja = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] p);
    pin   = p;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic end_txn(input string name);
    wait_sig(2, 1'b0, {name, "_idle"});
    check({name, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    int a_bad;
    int b_seen;

    reset   = 1'b1;
    start   = 1'b0;
    pin     = '0;
    Aguja   = 1'b0;
    Bloqueo = 1'b0;
    Alarma  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", int'({A, B, C, D, busy, done, fail, tries}), 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: normal pass, Aguja on 3rd WAIT_GATE cycle
    push_bits(16'hA5C3, 16);
    q.push_back('{1, 1});
    pulse_start(16'hA5C3);
    check("t1_busy", int'(busy), 1);
    check("t1_a_arrive", int'(A), 1);
    check("t1_d_arrive", int'(D), 0);
    gate(2);
    check("t1_a_pass", int'(A), 0);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (B) cnt++;
      else break;
    end
    check("t1_b_len", cnt, 4);
    check("t1_done_pulse", int'(done), 1);
    end_txn("t1");

    // 2: no gate, three bursts then fail
    push_bits(16'h1234, 16);
    push_bits(16'h1234, 16);
    push_bits(16'h1234, 16);
    q.push_back('{2, 3});
    pulse_start(16'h1234);
    wait_sig(0, 1'b1, "t2_d");
    n = 0;
    a_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (fail) break;
      if (!A) a_bad++;
      @(negedge clock);
      n++;
    end
    check("t2_span", n, 144);
    check("t2_a_held", a_bad, 0);
    check("t2_a_after", int'(A), 0);
    @(negedge clock);
    check("t2_idle", int'(busy), 0);
    check("t2_sb_empty", q.size(), 0);

    // 3: Alarma during bit 7
    push_bits(16'hF00D, 8);
    q.push_back('{2, 0});
    pulse_start(16'hF00D);
    wait_sig(0, 1'b1, "t3_d");
    repeat (7) @(negedge clock);
    Alarma = 1'b1;
    @(negedge clock);
    Alarma = 1'b0;
    check("t3_fail", int'(fail), 1);
    check("t3_acd_drop", int'({A, C, D}), 0);
    @(negedge clock);
    check("t3_idle", int'(busy), 0);
    check("t3_sb_empty", q.size(), 0);

    // 4: Aguja and Bloqueo together in WAIT_GATE
    push_bits(16'h0F0F, 16);
    q.push_back('{2, 1});
    pulse_start(16'h0F0F);
    wait_sig(0, 1'b1, "t4_d_rise");
    wait_sig(0, 1'b0, "t4_d_fall");
    Aguja   = 1'b1;
    Bloqueo = 1'b1;
    b_seen  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (B) b_seen = 1;
      if (!busy) break;
    end
    Aguja   = 1'b0;
    Bloqueo = 1'b0;
    check("t4_b_never", b_seen, 0);
    check("t4_idle", int'(busy), 0);
    check("t4_sb_empty", q.size(), 0);

    // 5: reset mid-PASS, then a clean transaction
    push_bits(16'h8001, 16);
    pulse_start(16'h8001);
    gate(0);
    @(negedge clock);
    check("t5_b_mid", int'(B), 1);
    reset = 1'b1;
    @(negedge clock);
    check("t5_reset_outputs", int'({A, B, C, D, busy, done, fail, tries}), 0);
    reset = 1'b0;
    check("t5_sb_after_reset", q.size(), 0);
    push_bits(16'h5A5A, 16);
    q.push_back('{1, 1});
    pulse_start(16'h5A5A);
    gate(0);
    end_txn("t5");

    // 6: start held high; pin changed mid-transaction must not be re-captured
    push_bits(16'hC0DE, 16);
    q.push_back('{1, 1});
    pin   = 16'hC0DE;
    start = 1'b1;
    wait_sig(0, 1'b1, "t6_d_rise");
    pin = 16'h3C69;
    push_bits(16'h3C69, 16);
    q.push_back('{1, 1});
    wait_sig(0, 1'b0, "t6_d_fall");
    Aguja = 1'b1;
    wait_sig(1, 1'b1, "t6_b_rise");
    Aguja = 1'b0;
    wait_sig(3, 1'b1, "t6_done");
    @(negedge clock);
    check("t6_idle_gap", int'(busy), 0);
    @(negedge clock);
    check("t6_restart", int'(busy), 1);
    start = 1'b0;
    gate(0);
    end_txn("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
